// File: rtl/gerencia_vagas_if.sv
// gerencia_vagas_if: parking occupancy bus.
// SE/SI raw sensor levels in; count, flags, pulses out.
interface gerencia_vagas_if;
  logic       SE;
  logic       SI;
  logic [3:0] Ocupacao;
  logic       Cheio;
  logic       Vazio;
  logic       Entrou;
  logic       Saiu;
  logic       ErroFluxo;

  modport master (
    output SE, SI,
    input  Ocupacao, Cheio, Vazio,
    input  Entrou, Saiu, ErroFluxo
  );

  modport slave (
    input  SE, SI,
    output Ocupacao, Cheio, Vazio,
    output Entrou, Saiu, ErroFluxo
  );
endinterface

// File: rtl/gerencia_vagas.sv
// gerencia_vagas: sensor sync/debounce, passage FSM, occupancy count.
// Ports: clock, reset (async, low), bus (slave: SE/SI in, status out).
module gerencia_vagas #(
  parameter int CAPACIDADE = 8,
  parameter int DEBOUNCE   = 16
) (
  input logic            clock,
  input logic            reset,
  gerencia_vagas_if.slave bus
);

  localparam logic [3:0] LP_CAP = 4'(CAPACIDADE);
  localparam logic [7:0] LP_DBM = 8'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    IDLE, ENT1, ENT2, ENT3,
    SAI1, SAI2, SAI3, ESPERA
  } st_t;

  // bit 1 = SE, bit 0 = SI throughout
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_deb;
  logic [7:0] r_cnt [2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_deb    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_s1 <= {bus.SE, bus.SI};
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        // any cycle agreeing with the held level restarts the count
        if (r_s2[i] != r_deb[i]) begin
          if (r_cnt[i] == LP_DBM) begin
            r_deb[i] <= r_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  st_t        r_state;
  logic [3:0] r_occ;
  logic       r_cheio;
  logic       r_vazio;
  logic       r_entrou;
  logic       r_saiu;
  logic       r_erro;

  st_t        w_nxt;
  logic       w_ent;
  logic       w_sai;
  logic       w_inc;
  logic       w_dec;
  logic       w_err;
  logic [3:0] w_occ_nxt;
  logic [1:0] w_lvl;

  assign w_lvl = r_deb;

  always_comb begin
    w_nxt = r_state;
    w_ent = 1'b0;
    w_sai = 1'b0;
    unique case (r_state)
      IDLE: begin
        case (w_lvl)
          2'b10:   w_nxt = ENT1;
          2'b01:   w_nxt = SAI1;
          2'b11:   w_nxt = ESPERA;
          default: w_nxt = IDLE;
        endcase
      end
      ENT1: begin
        case (w_lvl)
          2'b11:   w_nxt = ENT2;
          2'b00:   w_nxt = IDLE;
          default: w_nxt = ENT1;
        endcase
      end
      ENT2: begin
        case (w_lvl)
          2'b01:   w_nxt = ENT3;
          2'b10:   w_nxt = ENT1;
          2'b00:   w_nxt = IDLE;
          default: w_nxt = ENT2;
        endcase
      end
      ENT3: begin
        case (w_lvl)
          2'b00: begin
            w_nxt = IDLE;
            w_ent = 1'b1;
          end
          2'b11:   w_nxt = ENT2;
          2'b10:   w_nxt = ESPERA;
          default: w_nxt = ENT3;
        endcase
      end
      SAI1: begin
        case (w_lvl)
          2'b11:   w_nxt = SAI2;
          2'b00:   w_nxt = IDLE;
          default: w_nxt = SAI1;
        endcase
      end
      SAI2: begin
        case (w_lvl)
          2'b10:   w_nxt = SAI3;
          2'b01:   w_nxt = SAI1;
          2'b00:   w_nxt = IDLE;
          default: w_nxt = SAI2;
        endcase
      end
      SAI3: begin
        case (w_lvl)
          2'b00: begin
            w_nxt = IDLE;
            w_sai = 1'b1;
          end
          2'b11:   w_nxt = SAI2;
          2'b01:   w_nxt = ESPERA;
          default: w_nxt = SAI3;
        endcase
      end
      ESPERA: begin
        if (w_lvl == 2'b00) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // saturating count: a completion at a limit becomes an error pulse
  assign w_inc = w_ent && (r_occ < LP_CAP);
  assign w_dec = w_sai && (r_occ != 4'd0);
  assign w_err = (w_ent && !w_inc) ||
                 (w_sai && !w_dec);

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_inc) w_occ_nxt = r_occ + 4'd1;
    if (w_dec) w_occ_nxt = r_occ - 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_occ    <= '0;
      r_cheio  <= 1'b0;
      r_vazio  <= 1'b1;
      r_entrou <= 1'b0;
      r_saiu   <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_occ    <= w_occ_nxt;
      r_cheio  <= (w_occ_nxt == LP_CAP);
      r_vazio  <= (w_occ_nxt == 4'd0);
      r_entrou <= w_inc;
      r_saiu   <= w_dec;
      r_erro   <= w_err;
    end
  end

  assign bus.Ocupacao  = r_occ;
  assign bus.Cheio     = r_cheio;
  assign bus.Vazio     = r_vazio;
  assign bus.Entrou    = r_entrou;
  assign bus.Saiu      = r_saiu;
  assign bus.ErroFluxo = r_erro;

endmodule
